// File: rtl/mem_axi_lite_master.sv
`default_nettype none
// ============================================================================
// mem_axi_lite_master
// Bridges core-side memory requests to an AXI4-Lite master port, one
// transaction outstanding at a time.
// Revision: 1.0
// ============================================================================
module mem_axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rstn,
  // core side
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   mem_waddr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                            mem_wen,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   mem_raddr,
  input  logic                            mem_ren,
  output logic                            mem_wvalid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   mem_rdata,
  output logic                            mem_rvalid,
  // AXI4-Lite side
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                            axi_awvalid,
  input  logic                            axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                            axi_wvalid,
  input  logic                            axi_wready,
  input  logic [1:0]                      axi_bresp,
  input  logic                            axi_bvalid,
  output logic                            axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  output logic                            axi_arvalid,
  input  logic                            axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]                      axi_rresp,
  input  logic                            axi_rvalid,
  output logic                            axi_rready,
  // status
  output logic                            resp_err,
  output logic [2:0]                      debug_state
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] WDONE = 3'd3;
  localparam logic [2:0] RADDR = 3'd4;
  localparam logic [2:0] RDATA = 3'd5;
  localparam logic [2:0] RDONE = 3'd6;

  logic [2:0]                    state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic mem_wvalid_q, mem_wvalid_d, mem_rvalid_q, mem_rvalid_d;
  logic resp_err_q, resp_err_d;

  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    araddr_d     = araddr_q;
    rdata_d      = rdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    mem_wvalid_d = mem_wvalid_q;
    mem_rvalid_d = mem_rvalid_q;
    resp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_wen) begin
          awaddr_d  = mem_waddr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wmask;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WADDR;
        end else if (mem_ren) begin
          araddr_d  = mem_raddr;
          arvalid_d = 1'b1;
          state_d   = RADDR;
        end
      end
      WADDR: begin
        // Response phase starts only once both registered done flags agree.
        if (aw_done_q && w_done_q) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end else begin
          if (awvalid_q && axi_awready) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end
          if (wvalid_q && axi_wready) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end
        end
      end
      WRESP: begin
        if (axi_bvalid && bready_q) begin
          bready_d   = 1'b0;
          resp_err_d = |axi_bresp;
          state_d    = WDONE;
        end
      end
      WDONE: begin
        // Four-phase: completion is held until the core drops its enable.
        if (mem_wvalid_q && !mem_wen) begin
          mem_wvalid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          mem_wvalid_d = 1'b1;
        end
      end
      RADDR: begin
        if (arvalid_q && axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (axi_rvalid && rready_q) begin
          rdata_d    = axi_rdata;
          rready_d   = 1'b0;
          resp_err_d = |axi_rresp;
          state_d    = RDONE;
        end
      end
      RDONE: begin
        if (mem_rvalid_q && !mem_ren) begin
          mem_rvalid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          mem_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      araddr_q     <= '0;
      rdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      mem_wvalid_q <= 1'b0;
      mem_rvalid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      araddr_q     <= araddr_d;
      rdata_q      <= rdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      mem_wvalid_q <= mem_wvalid_d;
      mem_rvalid_q <= mem_rvalid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign mem_wvalid  = mem_wvalid_q;
  assign mem_rvalid  = mem_rvalid_q;
  assign mem_rdata   = rdata_q;
  assign resp_err    = resp_err_q;
  assign debug_state = state_q;

endmodule
`default_nettype wire

// File: doc/mem_axi_lite_master.md
# mem_axi_lite_master

Bridge from the core-side Mem_ift request interface to an AXI4-Lite master port. The block plays the memory slave toward the core (accepts wen/ren requests, returns wvalid/rvalid) and issues one AXI-Lite write or read per request. It sits between the core's memory stage and the AXI-Lite interconnect, opposite the memory-side AXI-Lite slave. One transaction is outstanding at a time.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, 64, AXI and Mem_ift data width; a multiple of 8.
- C_M_AXI_ADDR_WIDTH, 64, AXI and Mem_ift address width.

Ports:
- clk  in  1  single clock for the whole block; all logic is on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- mem_ift  Mem_ift.Slave  -  core side.
  - Inputs: Mw.waddr, Mw.wdata, Mw.wmask, Mw.wen, Mr.raddr, Mr.ren.
  - Outputs: Sw.wvalid, Sr.rdata, Sr.rvalid.
- master_ift  AXI_ift.Master  -  AXI-Lite side.
  - Outputs: Mw.awaddr, Mw.awvalid, Mw.wdata, Mw.wstrb, Mw.wvalid, Mw.bready, Mr.araddr, Mr.arvalid, Mr.rready.
  - Inputs: Sw.awready, Sw.wready, Sw.bresp, Sw.bvalid, Sr.arready, Sr.rdata, Sr.rresp, Sr.rvalid.
  - The clk/rstn fields of master_ift are not used; the block runs on the clk and rstn ports.
- resp_err  out  1  one-cycle pulse when a completed transaction returns a nonzero bresp or rresp.
- debug_state  out  3  current FSM state encoding.

## Operation
- FSM states: IDLE=0, WADDR=1, WRESP=2, WDONE=3, RADDR=4, RDATA=5, RDONE=6.
- IDLE:
  - If wen=1: capture waddr, wdata and wmask into the AW/W registers, then go to WADDR.
  - Else if ren=1: capture raddr into the AR register, then go to RADDR.
  - Write wins when wen and ren are both high; the read is served after the write's handshake completes.
- WADDR:
  - awvalid and wvalid are both driven high on entry. Each channel is tracked with its own done flag.
  - awvalid drops on the edge where awvalid&awready is sampled; wvalid drops the same way on wvalid&wready. Either order is allowed, including simultaneous.
  - When both flags are set, go to WRESP with bready=1.
- WRESP: on bvalid&bready, set bready=0 and go to WDONE. Pulse resp_err if bresp≠0.
- WDONE: mem Sw.wvalid=1, held until wen is sampled low; then wvalid=0 and go to IDLE.
- RADDR: arvalid=1 until arvalid&arready; then arvalid=0, rready=1, go to RDATA.
- RDATA: on rvalid&rready, capture rdata into the mem-side Sr.rdata register, set rready=0, go to RDONE. Pulse resp_err if rresp≠0.
- RDONE: Sr.rvalid=1 and Sr.rdata held stable until ren is sampled low; then rvalid=0 and go to IDLE.
- Four-phase core handshake: a request is not re-issued while wen/ren stays high after completion. A new request needs the enable to drop first.
- Data are passed through unmodified: no width conversion or alignment. wstrb = captured wmask.
- An error response still completes the core handshake normally.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE. Every valid, ready and strobe output, resp_err, Sw.wvalid and Sr.rvalid are 0. All address and data registers are 0.
- Valid outputs are registered, with no combinational path from input to output. AXI valids never depend on the matching ready.
- Once asserted, awvalid, wvalid and arvalid stay asserted with stable payload until their handshake completes.
- Write latency: wen sampled at edge N → awvalid/wvalid high after edge N. With zero-wait slave readies and bvalid, Sw.wvalid rises 4 cycles after the wen sample.
- Read latency: ren sampled at edge N → arvalid high after N. With zero-wait arready and rvalid, Sr.rvalid rises 3 cycles after the ren sample.
- A slave asserting ready before valid is legal; the handshake completes on the first cycle valid is high.
- Reset mid-transaction aborts immediately: all outputs drop. Only system-wide reset may do this.

## Test plan
- Single write, ready-always slave: wen with waddr=0x80, wdata=0xDEADBEEF_CAFEF00D, wmask=0xFF → exactly one AW/W beat with those values and wstrb=0xFF. Sw.wvalid high 4 cycles after the wen sample and held until wen drops.
- Skewed channels: wready asserted 3 cycles after awready → awvalid drops first, wvalid stays high, bready is asserted only after both complete. wen held high after Sw.wvalid produces no second write.
- Read with slave wait states: arready delayed 2 cycles, rvalid delayed 5 cycles, rdata=0x1234 → Sr.rdata=0x1234 with Sr.rvalid held stable until ren is low.
- Simultaneous wen and ren (addresses 0x10 and 0x18) → write to 0x10 completes first; read of 0x18 is issued only after wen drops.
- Error response: bresp=2'b10 → resp_err pulses for exactly one cycle and Sw.wvalid still asserts. Repeat for a read with rresp=2'b11.
- Async reset asserted while in WADDR → awvalid, wvalid and debug_state go to 0 with no clock edge. A new write after release proceeds normally.
